// File: rtl/canv_layer_mix.sv
`default_nettype none
// ============================================================================
// Module   : canv_layer_mix
// Purpose  : Multi-layer canvas pixel unpack, transparency, priority composite
//            and CLUT paint with display-sync alignment.
//            Optional collision flags enabled by CANV_MIX_COLLIDE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module canv_layer_mix #(
  parameter int LAYERS     = 2,
  parameter int WORD       = 32,
  parameter int CIDX_ADDRW = 8,
  parameter int BPC        = 5,
  parameter int CLUT_LAT   = 2,
  localparam int PIX_IDW   = $clog2(WORD),
  localparam int COLRW     = 3 * BPC
) (
  input  logic                         clk_pix,
  input  logic                         rst_pix,
  input  logic [LAYERS*WORD-1:0]       word,
  input  logic [LAYERS*PIX_IDW-1:0]    pix_id,
  input  logic [LAYERS-1:0]            paint,
  input  logic [LAYERS*2-1:0]          bpp_log2,
  input  logic [LAYERS*CIDX_ADDRW-1:0] pal_off,
  input  logic [LAYERS-1:0]            trans_en,
  input  logic [LAYERS*CIDX_ADDRW-1:0] trans_idx,
  input  logic [COLRW-1:0]             bg_colr,
  input  logic                         hsync,
  input  logic                         vsync,
  input  logic                         de,
  input  logic                         frame,
  output logic [CIDX_ADDRW-1:0]        clut_addr,
  input  logic [COLRW-1:0]             clut_dout,
  output logic                         disp_hsync,
  output logic                         disp_vsync,
  output logic                         disp_de,
  output logic                         disp_frame,
  output logic [BPC-1:0]               disp_r,
  output logic [BPC-1:0]               disp_g,
  output logic [BPC-1:0]               disp_b
`ifdef CANV_MIX_COLLIDE_EN
  ,
  output logic [LAYERS-1:0]            collide
`endif
);

  localparam int c_RAWW = 8;
  localparam int c_CMPW = (CIDX_ADDRW > c_RAWW) ? CIDX_ADDRW : c_RAWW;
  localparam int c_DLYW = 5;  // {any_hit, hsync, vsync, de, frame}

  // ---------------------------------------------------------------- S1 unpack
  logic [c_RAWW-1:0] w_raw [LAYERS];
  logic [LAYERS-1:0] w_hit;

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    logic [1:0]         w_bpp;
    logic [PIX_IDW-1:0] w_shamt;
    logic [c_RAWW-1:0]  w_mask;

    assign w_bpp = bpp_log2[2*l +: 2];
    // Masking pix_id to the pixels-per-word range then scaling by bpp is the
    // same as scaling first and dropping the carry out of the word.
    assign w_shamt = PIX_IDW'({3'b000, pix_id[l*PIX_IDW +: PIX_IDW]} << w_bpp);

    always_comb begin
      w_mask = 8'h01;
      case (w_bpp)
        2'd0:    w_mask = 8'h01;
        2'd1:    w_mask = 8'h03;
        2'd2:    w_mask = 8'h0F;
        default: w_mask = 8'hFF;
      endcase
    end

    assign w_raw[l] = c_RAWW'(word[l*WORD +: WORD] >> w_shamt) & w_mask;
    assign w_hit[l] = paint[l] & ~(trans_en[l] &
                      (c_CMPW'(w_raw[l]) == c_CMPW'(trans_idx[l*CIDX_ADDRW +: CIDX_ADDRW])));
  end

  logic [c_RAWW-1:0] r_s1_raw [LAYERS];
  logic [LAYERS-1:0] r_s1_hit;
  logic [3:0]        r_s1_sync;  // {hsync, vsync, de, frame}

  // ------------------------------------------------------------- S2 composite
  logic [c_RAWW-1:0]     w_win_raw;
  logic [CIDX_ADDRW-1:0] w_win_pal;
  logic                  w_any_hit;

  // Walk from the highest layer down so the lowest-numbered hit overrides.
  always_comb begin
    w_win_raw = '0;
    w_win_pal = '0;
    w_any_hit = 1'b0;
    for (int l = LAYERS - 1; l >= 0; l--) begin
      if (r_s1_hit[l]) begin
        w_win_raw = r_s1_raw[l];
        w_win_pal = pal_off[l*CIDX_ADDRW +: CIDX_ADDRW];
        w_any_hit = 1'b1;
      end
    end
  end

  logic              r_s2_hit;
  logic [3:0]        r_s2_sync;
  logic [c_DLYW-1:0] r_dly [CLUT_LAT];

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      for (int l = 0; l < LAYERS; l++) r_s1_raw[l] <= '0;
      r_s1_hit  <= '0;
      r_s1_sync <= '0;
      clut_addr <= '0;
      r_s2_hit  <= 1'b0;
      r_s2_sync <= '0;
      for (int k = 0; k < CLUT_LAT; k++) r_dly[k] <= '0;
    end else begin
      for (int l = 0; l < LAYERS; l++) r_s1_raw[l] <= w_raw[l];
      r_s1_hit  <= w_hit;
      r_s1_sync <= {hsync, vsync, de, frame};
      clut_addr <= CIDX_ADDRW'(w_win_raw) + w_win_pal;
      r_s2_hit  <= w_any_hit;
      r_s2_sync <= r_s1_sync;
      r_dly[0]  <= {r_s2_hit, r_s2_sync};
      for (int k = 1; k < CLUT_LAT; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  // ----------------------------------------------------------------- output
  logic [c_DLYW-1:0] w_tail;
  logic [COLRW-1:0]  w_rgb;

  assign w_tail = r_dly[CLUT_LAT-1];

  always_comb begin
    w_rgb = '0;
    if (w_tail[1]) w_rgb = w_tail[4] ? clut_dout : bg_colr;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      disp_hsync <= 1'b0;
      disp_vsync <= 1'b0;
      disp_de    <= 1'b0;
      disp_frame <= 1'b0;
      disp_r     <= '0;
      disp_g     <= '0;
      disp_b     <= '0;
    end else begin
      disp_hsync <= w_tail[3];
      disp_vsync <= w_tail[2];
      disp_de    <= w_tail[1];
      disp_frame <= w_tail[0];
      disp_r     <= w_rgb[2*BPC +: BPC];
      disp_g     <= w_rgb[BPC +: BPC];
      disp_b     <= w_rgb[0 +: BPC];
    end
  end

`ifdef CANV_MIX_COLLIDE_EN
  // Clearing the lowest set bit drops the winner and leaves every other hit.
  logic [LAYERS-1:0] w_coll;
  logic [LAYERS-1:0] r_coll_acc;

  assign w_coll = r_s1_sync[1] ? (r_s1_hit & (r_s1_hit - LAYERS'(1))) : '0;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      r_coll_acc <= '0;
      collide    <= '0;
    end else if (r_s1_sync[0]) begin
      collide    <= r_coll_acc;
      r_coll_acc <= w_coll;
    end else begin
      r_coll_acc <= r_coll_acc | w_coll;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_canv_layer_mix.sv
`default_nettype none
// ============================================================================
// Module   : tb_canv_layer_mix
// Purpose  : Self-checking bench for canv_layer_mix (2 layers, CLUT_LAT=2)
//            against a per-pixel arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_canv_layer_mix;

  localparam int LAT = 2;
  localparam int L   = 3 + LAT;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [63:0] word;
  logic [9:0]  pix_id;
  logic [1:0]  paint;
  logic [3:0]  bpp_log2;
  logic [15:0] pal_off;
  logic [1:0]  trans_en;
  logic [15:0] trans_idx;
  logic [14:0] bg_colr;
  logic        hsync, vsync, de, frame;
  logic [7:0]  clut_addr;
  logic [14:0] clut_dout;
  logic        disp_hsync, disp_vsync, disp_de, disp_frame;
  logic [4:0]  disp_r, disp_g, disp_b;
`ifdef CANV_MIX_COLLIDE_EN
  logic [1:0]  collide;
`endif

  int n_checks = 0;
  int n_errors = 0;

  canv_layer_mix #(.LAYERS(2), .WORD(32), .CIDX_ADDRW(8), .BPC(5), .CLUT_LAT(LAT)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .word(word), .pix_id(pix_id), .paint(paint),
    .bpp_log2(bpp_log2), .pal_off(pal_off), .trans_en(trans_en), .trans_idx(trans_idx),
    .bg_colr(bg_colr), .hsync(hsync), .vsync(vsync), .de(de), .frame(frame),
    .clut_addr(clut_addr), .clut_dout(clut_dout),
    .disp_hsync(disp_hsync), .disp_vsync(disp_vsync), .disp_de(disp_de),
    .disp_frame(disp_frame), .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b)
`ifdef CANV_MIX_COLLIDE_EN
    , .collide(collide)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  // CLUT memory with LAT-cycle read latency
  logic [14:0] clut_mem [256];
  logic [14:0] clut_q   [LAT];
  always @(posedge clk_pix) begin
    clut_q[0] <= clut_mem[clut_addr];
    for (int i = 1; i < LAT; i++) clut_q[i] <= clut_q[i-1];
  end
  assign clut_dout = clut_q[LAT-1];

  logic [18:0] disp_vec;
  assign disp_vec = {disp_hsync, disp_vsync, disp_de, disp_frame, disp_r, disp_g, disp_b};

  typedef struct {
    logic        rst;
    logic [63:0] word;
    logic [9:0]  pid;
    logic [1:0]  paint;
    logic [3:0]  bpp;
    logic [15:0] pal;
    logic [1:0]  ten;
    logic [15:0] tidx;
    logic [14:0] bg;
    logic        hs, vs, de, fr;
  } snap_t;

  snap_t hist[$];  // inputs captured at each clock edge, newest last

  // ---------------------------------------------------------- reference model
  function automatic logic [7:0] ref_raw(input logic [31:0] w, input logic [4:0] pid,
                                         input logic [1:0] b);
    int bits, per, idx;
    bits = 1 << b;
    per  = 32 / bits;
    idx  = int'(pid) % per;
    return 8'((w >> (idx * bits)) & ((32'd1 << bits) - 32'd1));
  endfunction

  function automatic logic ref_pick(input snap_t px, input logic [15:0] pal,
                                    output logic [7:0] addr);
    addr = 8'h00;
    for (int l = 0; l < 2; l++) begin
      logic [7:0] raw;
      raw = ref_raw(px.word[l*32 +: 32], px.pid[l*5 +: 5], px.bpp[l*2 +: 2]);
      if (px.paint[l] && !(px.ten[l] && raw == px.tidx[l*8 +: 8])) begin
        addr = raw + pal[l*8 +: 8];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic flushed(input int depth);
    if (hist.size() < depth) return 1'b1;
    for (int k = 1; k <= depth; k++) if (hist[hist.size()-k].rst) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_addr();
    logic [7:0] a;
    if (flushed(2)) return 8'h00;
    void'(ref_pick(hist[hist.size()-2], hist[hist.size()-1].pal, a));
    return a;
  endfunction

  function automatic logic [18:0] exp_disp();
    snap_t       px;
    logic [7:0]  a;
    logic        hit;
    logic [14:0] rgb;
    if (flushed(L)) return '0;
    px  = hist[hist.size()-L];
    hit = ref_pick(px, hist[hist.size()-L+1].pal, a);
    rgb = !px.de ? 15'h0 : (hit ? clut_mem[a] : hist[hist.size()-1].bg);
    return {px.hs, px.vs, px.de, px.fr, rgb};
  endfunction

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    snap_t s;
    s.rst = rst_pix; s.word = word; s.pid = pix_id; s.paint = paint; s.bpp = bpp_log2;
    s.pal = pal_off; s.ten = trans_en; s.tidx = trans_idx; s.bg = bg_colr;
    s.hs = hsync; s.vs = vsync; s.de = de; s.fr = frame;
    hist.push_back(s);
    if (hist.size() > 16) void'(hist.pop_front());
    @(posedge clk_pix);
    #1;
  endtask

  task automatic drive_quiet();
    rst_pix = 1'b0; word = '0; pix_id = '0; paint = '0; bpp_log2 = '0; pal_off = '0;
    trans_en = '0; trans_idx = '0; bg_colr = '0; hsync = 0; vsync = 0; de = 1; frame = 0;
  endtask

  task automatic drive_random();
    word      = {$urandom, $urandom};
    pix_id    = 10'($urandom);
    paint     = 2'($urandom);
    bpp_log2  = 4'($urandom);
    pal_off   = 16'($urandom);
    trans_en  = 2'($urandom);
    trans_idx = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
    bg_colr   = 15'($urandom);
    hsync     = 1'($urandom);
    vsync     = 1'($urandom);
    de        = ($urandom_range(0, 3) != 0);
    frame     = ($urandom_range(0, 15) == 0);
  endtask

  task automatic test_reset();
    drive_random();
    rst_pix = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (clut_addr !== 8'h00 || disp_vec !== 19'h0) begin
        n_errors++;
        $display("FAIL reset: clut_addr=%h disp=%h, required 0/0", clut_addr, disp_vec);
      end
    end
    drive_quiet();
    for (int k = 1; k <= L; k++) begin
      tick();
      n_checks++;
      if (disp_de !== (k == L)) begin
        n_errors++;
        $display("FAIL reset_release de: cycle %0d got %b required %b", k, disp_de, (k == L));
      end
    end
  endtask

  task automatic test_unpack();
    drive_quiet();
    paint = 2'b01; bpp_log2 = 4'b0010; word = {32'h0, 32'h8765_4321};
    for (int k = 0; k < 8 + L; k++) begin
      pix_id = {5'd0, 5'(k)};
      tick();
      n_checks += 2;
      if (k > 0 && k < 9 && clut_addr !== 8'(k)) begin
        n_errors++;
        $display("FAIL unpack addr: pid %0d got %h required %h", k - 1, clut_addr, 8'(k));
      end
      if (clut_addr !== exp_addr()) begin
        n_errors++;
        $display("FAIL unpack addr model: got %h required %h", clut_addr, exp_addr());
      end
      if (disp_vec !== exp_disp()) begin
        n_errors++;
        $display("FAIL unpack disp: got %h required %h", disp_vec, exp_disp());
      end
    end
  endtask

  task automatic test_wrap();
    drive_quiet();
    paint = 2'b01; bpp_log2 = 4'b0011; word = {32'h0, 32'hAABB_CCDD};
    pix_id = {5'd0, 5'd5}; pal_off = 16'h00F0;
    tick();
    tick();
    n_checks++;
    if (clut_addr !== 8'hBC) begin
      n_errors++;
      $display("FAIL wrap addr: got %h required bc", clut_addr);
    end
  endtask

  task automatic test_priority();
    drive_quiet();
    paint = 2'b11; bpp_log2 = 4'b1111; trans_en = 2'b01; trans_idx = 16'h0000;
    word = {32'h0000_0007, 32'h0000_0000};
    tick();
    tick();
    n_checks++;
    if (clut_addr !== 8'h07) begin
      n_errors++;
      $display("FAIL priority transparent: got %h required 07", clut_addr);
    end
    word = {32'h0000_0007, 32'h0000_0003};
    tick();
    tick();
    n_checks++;
    if (clut_addr !== 8'h03) begin
      n_errors++;
      $display("FAIL priority layer0: got %h required 03", clut_addr);
    end
  endtask

  task automatic test_background();
    drive_quiet();
    bg_colr = 15'h7C00;
    for (int k = 0; k < L; k++) tick();
    n_checks++;
    if ({disp_r, disp_g, disp_b} !== 15'h7C00) begin
      n_errors++;
      $display("FAIL background rgb: got %h required 7c00", {disp_r, disp_g, disp_b});
    end
    de = 0; paint = 2'b11; word = {$urandom, $urandom};
    for (int k = 0; k < L; k++) tick();
    n_checks++;
    if ({disp_r, disp_g, disp_b} !== 15'h0) begin
      n_errors++;
      $display("FAIL blank rgb: got %h required 0", {disp_r, disp_g, disp_b});
    end
  endtask

  task automatic test_midline_reset();
    for (int k = 0; k < 6; k++) begin
      drive_random();
      de = 1;
      tick();
    end
    rst_pix = 1'b1;
    tick();
    n_checks++;
    if (disp_vec !== 19'h0 || clut_addr !== 8'h00) begin
      n_errors++;
      $display("FAIL midline reset: disp=%h addr=%h required 0/0", disp_vec, clut_addr);
    end
    rst_pix = 1'b0;
    for (int k = 1; k <= L; k++) begin
      tick();
      n_checks++;
      if (disp_de !== (k == L)) begin
        n_errors++;
        $display("FAIL midline release de: cycle %0d got %b required %b", k, disp_de, (k == L));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive_random();
      rst_pix = ($urandom_range(0, 63) == 0);
      tick();
      n_checks += 2;
      if (clut_addr !== exp_addr()) begin
        n_errors++;
        $display("FAIL random addr: cycle %0d got %h required %h", k, clut_addr, exp_addr());
      end
      if (disp_vec !== exp_disp()) begin
        n_errors++;
        $display("FAIL random disp: cycle %0d got %h required %h", k, disp_vec, exp_disp());
      end
    end
  endtask

`ifdef CANV_MIX_COLLIDE_EN
  task automatic test_collide();
    drive_quiet();
    rst_pix = 1'b1;
    tick();
    drive_quiet();
    bpp_log2 = 4'b1111; word = {32'h11, 32'h11};
    frame = 1; tick();
    frame = 0; tick();
    paint = 2'b11; tick();
    paint = 2'b00; tick(); tick();
    n_checks++;
    if (collide !== 2'b00) begin
      n_errors++;
      $display("FAIL collide early: got %b required 00", collide);
    end
    frame = 1; tick();
    frame = 0; tick();
    n_checks++;
    if (collide !== 2'b10) begin
      n_errors++;
      $display("FAIL collide overlap: got %b required 10", collide);
    end
    paint = 2'b01; tick(); tick();
    frame = 1; tick();
    frame = 0; tick();
    n_checks++;
    if (collide !== 2'b00) begin
      n_errors++;
      $display("FAIL collide clear: got %b required 00", collide);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) clut_mem[i] = 15'($urandom);
    for (int i = 0; i < LAT; i++) clut_q[i] = '0;
    drive_quiet();
    test_reset();
    test_unpack();
    test_wrap();
    test_priority();
    test_background();
    test_midline_reset();
    test_random();
`ifdef CANV_MIX_COLLIDE_EN
    test_collide();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
